// File: rtl/wb_gpio_slave.sv
`default_nettype none
// ============================================================================
// Module      : wb_gpio_slave
// Description : Pipelined Wishbone slave exposing WIDTH bidirectional GPIO
//               pins with direction control, a 2-FF input synchroniser,
//               sticky rising-edge flags and a maskable level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_gpio_slave #(
    parameter int         WIDTH     = 8,
    parameter logic       SYNC_INIT = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_resetn,
    input  logic [31:0]       i_wb_addr,
    input  logic [31:0]       i_wb_data,
    input  logic [3:0]        i_wb_sel,
    input  logic              i_wb_we,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    output logic              o_wb_ack,
    output logic              o_wb_err,
    output logic              o_wb_stall,
    output logic [31:0]       o_wb_data,
    inout  wire  [WIDTH-1:0]  io_gpio,
    output logic              o_irq
);

    // Word offsets decoded from i_wb_addr[4:2]
    localparam logic [2:0] c_off_out   = 3'd0;
    localparam logic [2:0] c_off_dir   = 3'd1;
    localparam logic [2:0] c_off_in    = 3'd2;
    localparam logic [2:0] c_off_rise  = 3'd3;
    localparam logic [2:0] c_off_irqen = 3'd4;

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_irqen;
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_hist;
    logic             r_ack;
    logic             r_err;
    logic             r_stall;
    logic             r_irq;
    logic [31:0]      r_rdata;

    logic [2:0]       w_off;
    logic             w_accept;
    logic             w_mapped;
    logic             w_wr;
    logic [31:0]      w_mask32;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_rise_clr;
    logic [WIDTH-1:0] w_rise_next;
    logic [WIDTH-1:0] w_irqen_next;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_off    = i_wb_addr[4:2];
    // Stall is high exactly during the response cycle, so at most one
    // request is ever outstanding.
    assign w_accept = i_wb_cyc & i_wb_stb & ~r_stall;
    assign w_mapped = (w_off <= c_off_irqen);
    // Unmapped offsets must not change any state.
    assign w_wr     = w_accept & i_wb_we & w_mapped;
    assign w_wdata  = i_wb_data[WIDTH-1:0];
    assign w_edge   = r_sync2 & ~r_hist;

    // Expand byte-lane enables into a per-bit write mask truncated to WIDTH
    always_comb begin
        w_mask32 = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
        w_mask   = w_mask32[WIDTH-1:0];
    end

    // Next values of RISE and IRQEN; an edge in the same cycle as a clear wins
    always_comb begin
        w_rise_clr   = '0;
        w_irqen_next = r_irqen;
        if (w_wr && (w_off == c_off_rise)) begin
            w_rise_clr = w_wdata & w_mask;
        end
        if (w_wr && (w_off == c_off_irqen)) begin
            w_irqen_next = (r_irqen & ~w_mask) | (w_wdata & w_mask);
        end
        w_rise_next = (r_rise & ~w_rise_clr) | w_edge;
    end

    // Read mux, zero-extended above WIDTH; unmapped offsets read as zero
    always_comb begin
        w_rdata = '0;
        case (w_off)
            c_off_out:   w_rdata[WIDTH-1:0] = r_out;
            c_off_dir:   w_rdata[WIDTH-1:0] = r_dir;
            c_off_in:    w_rdata[WIDTH-1:0] = r_sync2;
            c_off_rise:  w_rdata[WIDTH-1:0] = r_rise;
            c_off_irqen: w_rdata[WIDTH-1:0] = r_irqen;
            default:     w_rdata = '0;
        endcase
    end

    // Bus response, control registers and interrupt
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_out   <= '0;
            r_dir   <= '0;
            r_rise  <= '0;
            r_irqen <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_stall <= 1'b0;
            r_irq   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= w_accept & w_mapped;
            r_err   <= w_accept & ~w_mapped;
            r_stall <= w_accept;
            if (w_accept) begin
                r_rdata <= w_rdata;
            end
            if (w_wr && (w_off == c_off_out)) begin
                r_out <= (r_out & ~w_mask) | (w_wdata & w_mask);
            end
            if (w_wr && (w_off == c_off_dir)) begin
                r_dir <= (r_dir & ~w_mask) | (w_wdata & w_mask);
            end
            r_rise  <= w_rise_next;
            r_irqen <= w_irqen_next;
            r_irq   <= |(w_rise_next & w_irqen_next);
        end
    end

    // Two-stage input synchroniser plus edge history
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_sync1 <= {WIDTH{SYNC_INIT}};
            r_sync2 <= {WIDTH{SYNC_INIT}};
            r_hist  <= {WIDTH{SYNC_INIT}};
        end else begin
            r_sync1 <= io_gpio;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    // Per-pin tristate drivers
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pins
            assign io_gpio[gi] = r_dir[gi] ? r_out[gi] : 1'bz;
        end
    endgenerate

    assign o_wb_ack   = r_ack;
    assign o_wb_err   = r_err;
    assign o_wb_stall = r_stall;
    assign o_wb_data  = r_rdata;
    assign o_irq      = r_irq;

    // Address bits outside [4:2] and data/mask bits above WIDTH are don't-care
    assign w_unused = &{1'b0, i_wb_addr, i_wb_data, w_mask32};

endmodule
`default_nettype wire

// File: tb/tb_wb_gpio_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_gpio_slave
// Description : Directed self-checking bench for wb_gpio_slave (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_gpio_slave;

    localparam int WIDTH = 8;

    logic              clk = 1'b0;
    logic              resetn;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [3:0]        sel;
    logic              we;
    logic              cyc;
    logic              stb;
    wire               ack;
    wire               err;
    wire               stall;
    wire  [31:0]       rdata;
    wire  [WIDTH-1:0]  gpio;
    wire               irq;
    logic [WIDTH-1:0]  tb_en;
    logic [WIDTH-1:0]  tb_val;
    logic [31:0]       scratch;
    int                checks   = 0;
    int                failures = 0;

    always #5 clk = ~clk;

    // External pin drivers (emulate pull-ups / external sources)
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_drv
            assign gpio[gi] = tb_en[gi] ? tb_val[gi] : 1'bz;
        end
    endgenerate

    wb_gpio_slave #(.WIDTH(WIDTH), .SYNC_INIT(1'b0)) dut (
        .i_clk      (clk),
        .i_resetn   (resetn),
        .i_wb_addr  (addr),
        .i_wb_data  (wdata),
        .i_wb_sel   (sel),
        .i_wb_we    (we),
        .i_wb_cyc   (cyc),
        .i_wb_stb   (stb),
        .o_wb_ack   (ack),
        .o_wb_err   (err),
        .o_wb_stall (stall),
        .o_wb_data  (rdata),
        .io_gpio    (gpio),
        .o_irq      (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One bus transaction: checks response pulse, stall window and return data
    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic w, input logic exp_err, input string tag,
                        output logic [31:0] rd);
        int n;
        n = 0;
        @(negedge clk);
        while (stall !== 1'b0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle_stall"}, {31'b0, stall}, 32'd0);
        addr = a; wdata = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_ack"},   {31'b0, ack},   {31'b0, ~exp_err});
        chk({tag, "_err"},   {31'b0, err},   {31'b0, exp_err});
        chk({tag, "_stall"}, {31'b0, stall}, 32'd1);
        rd = rdata;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        @(posedge clk); #1;
        chk({tag, "_ack_end"},   {31'b0, ack | err}, 32'd0);
        chk({tag, "_stall_end"}, {31'b0, stall},     32'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input string tag);
        logic [31:0] v;
        xfer(a, d, s, 1'b1, 1'b0, tag, v);
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] v;
        xfer(a, 32'h0, 4'hF, 1'b0, 1'b0, tag, v);
        chk({tag, "_data"}, v, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0; addr = '0; wdata = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
        tb_en = '1; tb_val = '1;

        // 1 Reset with pins pulled high
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pins",  {24'b0, gpio},  32'h0000_00FF);
        chk("rst_ack",   {31'b0, ack},   32'd0);
        chk("rst_err",   {31'b0, err},   32'd0);
        chk("rst_irq",   {31'b0, irq},   32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_data",  rdata,          32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        rd_chk(32'h08, 32'h0000_00FF, "in_after_rst");
        wr(32'h0C, 32'hFF, 4'hF, "rise_clr_init");
        rd_chk(32'h0C, 32'h0, "rise_zero");

        // 2 Drive pins from OUT
        tb_en = '0;
        wr(32'h04, 32'hFF, 4'hF, "dir_ff");
        wr(32'h00, 32'hA5, 4'b0001, "out_a5");
        chk("pins_a5", {24'b0, gpio}, 32'h0000_00A5);
        rd_chk(32'h00, 32'h0000_00A5, "out_rd");
        rd_chk(32'h08, 32'h0000_00A5, "in_driven");

        // 3 Byte lanes
        wr(32'h00, 32'h0000_003C, 4'b0000, "sel0");
        rd_chk(32'h00, 32'h0000_00A5, "sel0_hold");
        wr(32'h00, 32'hFFFF_FF00, 4'b1110, "sel_upper");
        rd_chk(32'h00, 32'h0000_00A5, "sel_upper_hold");
        chk("pins_hold", {24'b0, gpio}, 32'h0000_00A5);

        // 4 Edge detection and interrupt
        wr(32'h04, 32'h0, 4'hF, "dir_0");
        tb_en = '1; tb_val = '0;
        repeat (4) @(posedge clk);
        wr(32'h0C, 32'hFF, 4'hF, "rise_clr_all");
        rd_chk(32'h0C, 32'h0, "rise_clean");
        wr(32'h10, 32'h01, 4'hF, "irqen_1");
        chk("irq_idle", {31'b0, irq}, 32'd0);
        @(negedge clk);
        tb_val = 8'h01;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("irq_pre_edge", {31'b0, irq}, 32'd0);
        @(posedge clk); #1;
        chk("irq_set", {31'b0, irq}, 32'd1);
        rd_chk(32'h0C, 32'h01, "rise_set");
        wr(32'h0C, 32'h01, 4'hF, "rise_w1c");
        chk("irq_cleared", {31'b0, irq}, 32'd0);
        rd_chk(32'h0C, 32'h0, "rise_after_w1c");

        // 5 Edge and clear in the same cycle: set wins
        @(negedge clk);
        tb_val = 8'h00;
        repeat (4) @(posedge clk);
        rd_chk(32'h0C, 32'h0, "rise_pre_collision");
        @(negedge clk);
        tb_val = 8'h01;
        @(posedge clk);
        @(posedge clk);
        wr(32'h0C, 32'h01, 4'hF, "collision_w1c");
        rd_chk(32'h0C, 32'h01, "collision_set_wins");
        chk("collision_irq", {31'b0, irq}, 32'd1);

        // 6 Unmapped offsets and reset during a response
        xfer(32'h18, 32'h0, 4'hF, 1'b0, 1'b1, "unmapped_rd", scratch);
        xfer(32'h14, 32'h0, 4'hF, 1'b1, 1'b1, "unmapped_wr", scratch);
        xfer(32'h1C, 32'hFF, 4'hF, 1'b1, 1'b1, "unmapped_wr1c", scratch);
        rd_chk(32'h00, 32'h0000_00A5, "out_after_err");
        rd_chk(32'h10, 32'h01, "irqen_after_err");
        rd_chk(32'h04, 32'h0, "dir_after_err");
        tb_val = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        addr = 32'h0; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        chk("rstresp_ack",  {31'b0, ack}, 32'd1);
        chk("rstresp_data", rdata,        32'h0000_00A5);
        @(negedge clk);
        resetn = 1'b0; cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        chk("rstresp_ack_drop", {31'b0, ack},   32'd0);
        chk("rstresp_stall",    {31'b0, stall}, 32'd0);
        chk("rstresp_data_clr", rdata,          32'd0);
        chk("rstresp_irq",      {31'b0, irq},   32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        rd_chk(32'h00, 32'h0, "out_rst");
        rd_chk(32'h04, 32'h0, "dir_rst");
        rd_chk(32'h0C, 32'h0, "rise_rst");
        rd_chk(32'h10, 32'h0, "irqen_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
